// File: rtl/clk_sink_monitor.sv
// Clock sink health monitor: counts synchronized rising edges of A over fixed CLK windows
// and reports OK / FAIL_LOW / FAIL_HIGH. Define CLK_SINK_MONITOR_STICKY_EN for sticky fail flags.
`timescale 1ns/1ps
module clk_sink_monitor #(
    parameter int WIN_LEN     = 64,
    parameter int CNT_W       = 8,
    parameter int MIN_EDGES   = 12,
    parameter int MAX_EDGES   = 20,
    parameter int SYNC_STAGES = 2
) (
    input  logic             CLK,
    input  logic             RN,
    input  logic             EN,
    input  logic             A,
    output logic             DONE,
    output logic             OK,
    output logic             FAIL_LOW,
    output logic             FAIL_HIGH,
    output logic [CNT_W-1:0] EDGE_CNT
);

    localparam int WIN_W = $clog2(WIN_LEN);
    localparam int SET_W = $clog2(SYNC_STAGES + 1);

    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WIN_LEN - 1);
    localparam logic [SET_W-1:0] SET_LAST = SET_W'(SYNC_STAGES);
    localparam logic [CNT_W-1:0] MIN_C    = CNT_W'(MIN_EDGES);
    localparam logic [CNT_W-1:0] MAX_C    = CNT_W'(MAX_EDGES);

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        COUNT,
        REPORT
    } state_t;

    state_t state, state_nxt;

    logic [SYNC_STAGES-1:0] a_sync;
    logic                   a_dly;
    logic                   rise;
    logic [SET_W-1:0]       settle_cnt;
    logic [WIN_W-1:0]       win_cnt;
    logic [CNT_W-1:0]       edge_cnt;
    logic                   low_now;
    logic                   high_now;
    logic                   fl_nxt;
    logic                   fh_nxt;
    logic                   ok_nxt;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    assign rise = a_sync[SYNC_STAGES-1] & ~a_dly;

    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (EN) state_nxt = SETTLE;
            SETTLE:  if (!EN) state_nxt = IDLE;
                     else if (settle_cnt == SET_LAST) state_nxt = COUNT;
            COUNT:   if (!EN) state_nxt = IDLE;
                     else if (win_cnt == WIN_LAST) state_nxt = REPORT;
            REPORT:  state_nxt = EN ? COUNT : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Verdict for the window just closed; sticky build accumulates failures until reset.
    always_comb begin
        low_now  = (edge_cnt < MIN_C);
        high_now = (edge_cnt > MAX_C);
`ifdef CLK_SINK_MONITOR_STICKY_EN
        fl_nxt   = FAIL_LOW | low_now;
        fh_nxt   = FAIL_HIGH | high_now;
`else
        fl_nxt   = low_now;
        fh_nxt   = high_now;
`endif
        ok_nxt   = ~fl_nxt & ~fh_nxt;
    end

    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            a_sync     <= '0;
            a_dly      <= 1'b0;
            settle_cnt <= '0;
            win_cnt    <= '0;
            edge_cnt   <= '0;
            DONE       <= 1'b0;
            OK         <= 1'b0;
            FAIL_LOW   <= 1'b0;
            FAIL_HIGH  <= 1'b0;
            EDGE_CNT   <= '0;
        end else begin
            a_sync <= {a_sync[SYNC_STAGES-2:0], A};
            a_dly  <= a_sync[SYNC_STAGES-1];
            DONE   <= 1'b0;
            case (state)
                IDLE: begin
                    settle_cnt <= '0;
                    win_cnt    <= '0;
                    edge_cnt   <= '0;
                end
                SETTLE: begin
                    settle_cnt <= settle_cnt + 1'b1;
                    win_cnt    <= '0;
                    edge_cnt   <= '0;
                end
                COUNT: begin
                    settle_cnt <= '0;
                    win_cnt    <= win_cnt + 1'b1;
                    if (rise) edge_cnt <= sat_inc(edge_cnt);
                end
                REPORT: begin
                    // An edge seen while reporting opens the next window's tally.
                    settle_cnt <= '0;
                    win_cnt    <= '0;
                    edge_cnt   <= {{(CNT_W-1){1'b0}}, rise};
                    DONE       <= 1'b1;
                    EDGE_CNT   <= edge_cnt;
                    OK         <= ok_nxt;
                    FAIL_LOW   <= fl_nxt;
                    FAIL_HIGH  <= fh_nxt;
                end
                default: begin
                    settle_cnt <= '0;
                    win_cnt    <= '0;
                    edge_cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_clk_sink_monitor.sv
// Self-checking bench for clk_sink_monitor: table vectors, corner sequences and random A
// streams scored against a window-sum model of the sampled input.
`timescale 1ns/1ps
module tb_clk_sink_monitor;

    localparam int WIN    = 64;
    localparam int SYNC   = 2;
    localparam int PER    = WIN + 1;
    localparam int HMAX   = 20000;
    localparam int M_ZERO = 0;
    localparam int M_PER  = 1;
    localparam int M_BURST = 2;
    localparam int M_RAND = 3;

    logic       CLK = 1'b0;
    logic       RN  = 1'b0;
    logic       EN  = 1'b0;
    logic       A   = 1'b0;
    logic       done, ok, fl, fh;
    logic [7:0] ecnt;
    logic       done4, ok4, fl4, fh4;
    logic [3:0] ecnt4;

    clk_sink_monitor dut (
        .CLK(CLK), .RN(RN), .EN(EN), .A(A),
        .DONE(done), .OK(ok), .FAIL_LOW(fl), .FAIL_HIGH(fh), .EDGE_CNT(ecnt)
    );

    clk_sink_monitor #(.CNT_W(4), .MAX_EDGES(12)) dut4 (
        .CLK(CLK), .RN(RN), .EN(EN), .A(A),
        .DONE(done4), .OK(ok4), .FAIL_LOW(fl4), .FAIL_HIGH(fh4), .EDGE_CNT(ecnt4)
    );

    always #5 CLK = ~CLK;

    // cyc = index of the current cycle; a_hist[c] = A as seen by the flops at posedge c
    int cyc = 0;
    bit a_hist [0:HMAX-1];
    always @(posedge CLK) begin
        cyc <= cyc + 1;
        if (cyc + 1 < HMAX) a_hist[cyc + 1] <= RN ? A : 1'b0;
    end

    int a_mode = M_ZERO;
    int a_per  = 4;
    int a_prob = 50;
    int c0     = 0;
    bit pulse [0:255];
    int drv_s, drv_r;

    initial begin
        forever begin
            @(posedge CLK);
            #2;
            drv_s = cyc + 1;
            drv_r = drv_s - c0;
            case (a_mode)
                M_PER:   A = ((drv_s % a_per) < (a_per / 2));
                M_BURST: A = (drv_r >= 0 && drv_r < 256) ? pulse[drv_r] : 1'b0;
                M_RAND:  if (int'($urandom_range(99, 0)) < a_prob) A = ~A;
                default: A = 1'b0;
            endcase
        end
    end

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d", nm, act, exp);
        end
    endtask

    // Reference: a rising edge of the sampled stream is seen SYNC-1 cycles later; a window
    // owns its 64 counting cycles, and later windows also own the preceding report cycle.
    function automatic int vis(input int c);
        if (c < SYNC) return 0;
        return (a_hist[c-SYNC+1] && !a_hist[c-SYNC]) ? 1 : 0;
    endfunction

    function automatic int win_count(input int n, input int cap);
        int lo, hi, sum;
        lo  = (n == 0) ? c0 : c0 + PER * n - 1;
        hi  = c0 + PER * n + WIN - 1;
        sum = 0;
        for (int c = lo; c <= hi; c++) sum += vis(c);
        return (sum > cap) ? cap : sum;
    endfunction

    bit st_fl, st_fh, st_fl4, st_fh4;
    int e_cnt;
    bit e_ok, e_fl, e_fh;

    task automatic verdict(input int cnt, input int mn, input int mx,
                           inout bit sfl, inout bit sfh,
                           output bit eok, output bit efl, output bit efh);
        efl = (cnt < mn);
        efh = (cnt > mx);
`ifdef CLK_SINK_MONITOR_STICKY_EN
        sfl = sfl | efl;
        sfh = sfh | efh;
        efl = sfl;
        efh = sfh;
`endif
        eok = !efl && !efh;
    endtask

    task automatic wait_cycle(input int c);
        while (cyc < c) @(negedge CLK);
    endtask

    task automatic do_reset();
        a_mode = M_ZERO;
        EN     = 1'b0;
        repeat (4) @(negedge CLK);
        RN = 1'b0;
        st_fl = 0; st_fh = 0; st_fl4 = 0; st_fh4 = 0;
        @(negedge CLK);
        RN = 1'b1;
    endtask

    task automatic start_en();
        c0 = cyc + SYNC + 2;
        EN = 1'b1;
    endtask

    task automatic wait_done(input int n, input string tag);
        int d;
        d = c0 + PER * (n + 1);
        wait_cycle(d - 1);
        chk({tag, "_done_early"}, done, 0);
        wait_cycle(d);
        chk({tag, "_done"}, done, 1);
    endtask

    task automatic check_model(input int n, input string tag);
        int c4;
        bit o4, l4, h4;
        wait_done(n, tag);
        e_cnt = win_count(n, 255);
        verdict(e_cnt, 12, 20, st_fl, st_fh, e_ok, e_fl, e_fh);
        c4 = win_count(n, 15);
        verdict(c4, 12, 12, st_fl4, st_fh4, o4, l4, h4);
        chk({tag, "_cnt"}, ecnt, e_cnt);
        chk({tag, "_ok"}, ok, e_ok);
        chk({tag, "_fl"}, fl, e_fl);
        chk({tag, "_fh"}, fh, e_fh);
        chk({tag, "_cnt4"}, ecnt4, c4);
        chk({tag, "_ok4"}, ok4, o4);
        chk({tag, "_fl4"}, fl4, l4);
        chk({tag, "_fh4"}, fh4, h4);
    endtask

    task automatic set_burst(input int n, input int xr);
        for (int i = 0; i < 256; i++) pulse[i] = 1'b0;
        for (int i = 0; i < n; i++) pulse[5 + 2 * i] = 1'b1;
        if (xr >= 0) pulse[xr] = 1'b1;
    endtask

    typedef struct {
        int mode; int arg; int xr;
        int cnt;  bit ok;  bit fl;  bit fh;
        int cnt4; bit ok4; bit fl4; bit fh4;
    } vec_t;
    vec_t tab [8];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int dn;
        string t;
        tab[0] = '{M_PER,   4, -1, 16, 1, 0, 0, 15, 0, 0, 1};
        tab[1] = '{M_ZERO,  0, -1,  0, 0, 1, 0,  0, 0, 1, 0};
        tab[2] = '{M_PER,   2, -1, 32, 0, 0, 1, 15, 0, 0, 1};
        tab[3] = '{M_BURST, 12, -1, 12, 1, 0, 0, 12, 1, 0, 0};
        tab[4] = '{M_BURST, 20, -1, 20, 1, 0, 0, 15, 0, 0, 1};
        tab[5] = '{M_BURST, 11, -1, 11, 0, 1, 0, 11, 0, 1, 0};
        tab[6] = '{M_BURST, 21, -1, 21, 0, 0, 1, 15, 0, 0, 1};
        tab[7] = '{M_BURST, 11, 62, 12, 1, 0, 0, 12, 1, 0, 0};

        repeat (2) @(negedge CLK);
        chk("rst_done", done, 0);
        chk("rst_ok", ok, 0);
        chk("rst_fl", fl, 0);
        chk("rst_fh", fh, 0);
        chk("rst_cnt", ecnt, 0);
        RN = 1'b1;

        // Table vectors: first window after a fresh start
        for (int i = 0; i < 8; i++) begin
            do_reset();
            a_mode = tab[i].mode;
            a_per  = tab[i].arg;
            if (tab[i].mode == M_BURST) set_burst(tab[i].arg, tab[i].xr);
            start_en();
            t = $sformatf("tab%0d", i);
            wait_done(0, t);
            chk({t, "_cnt"}, ecnt, tab[i].cnt);
            chk({t, "_ok"}, ok, tab[i].ok);
            chk({t, "_fl"}, fl, tab[i].fl);
            chk({t, "_fh"}, fh, tab[i].fh);
            chk({t, "_cnt4"}, ecnt4, tab[i].cnt4);
            chk({t, "_ok4"}, ok4, tab[i].ok4);
            chk({t, "_fl4"}, fl4, tab[i].fl4);
            chk({t, "_fh4"}, fh4, tab[i].fh4);
        end

        // Steady period-4 clock: windows repeat every WIN+1 cycles
        do_reset();
        a_mode = M_PER; a_per = 4;
        start_en();
        for (int n = 0; n < 3; n++) check_model(n, $sformatf("per4_w%0d", n));

        // Edge in the report cycle is credited to the following window
        do_reset();
        a_mode = M_BURST; set_burst(11, 63);
        start_en();
        wait_done(0, "rep_w0");
        chk("rep_w0_cnt", ecnt, 11);
        chk("rep_w0_fl", fl, 1);
        wait_done(1, "rep_w1");
        chk("rep_w1_cnt", ecnt, 1);

        // Dead clock recovers: flags follow the latest window unless sticky
        do_reset();
        a_mode = M_ZERO;
        start_en();
        check_model(0, "dead_w0");
        chk("dead_w0_fl_const", fl, 1);
        a_mode = M_PER; a_per = 4;
        check_model(1, "dead_w1");
`ifdef CLK_SINK_MONITOR_STICKY_EN
        chk("dead_w1_fl_const", fl, 1);
        chk("dead_w1_ok_const", ok, 0);
`else
        chk("dead_w1_fl_const", fl, 0);
        chk("dead_w1_ok_const", ok, 1);
`endif

        // EN dropped mid-window: no verdict, outputs hold, restart gives full latency
        do_reset();
        a_mode = M_PER; a_per = 4;
        start_en();
        check_model(0, "endrop_w0");
        wait_cycle(c0 + PER + 30);
        EN = 1'b0;
        dn = 0;
        for (int k = 0; k < 150; k++) begin
            @(negedge CLK);
            if (done) dn++;
        end
        chk("endrop_no_done", dn, 0);
        chk("endrop_hold_cnt", ecnt, e_cnt);
        chk("endrop_hold_ok", ok, e_ok);
        chk("endrop_hold_fl", fl, e_fl);
        chk("endrop_hold_fh", fh, e_fh);
        start_en();
        check_model(0, "endrop_re");

        // Reset pulse mid-window clears outputs at once, then full restart latency
        do_reset();
        a_mode = M_PER; a_per = 4;
        start_en();
        check_model(0, "rstmid_w0");
        chk("rstmid_ok_before", ok, 1);
        wait_cycle(c0 + PER + 34);
        a_mode = M_ZERO;
        wait_cycle(c0 + PER + 40);
        RN = 1'b0;
        #1;
        chk("rstmid_done", done, 0);
        chk("rstmid_ok", ok, 0);
        chk("rstmid_fl", fl, 0);
        chk("rstmid_fh", fh, 0);
        chk("rstmid_cnt", ecnt, 0);
        st_fl = 0; st_fh = 0; st_fl4 = 0; st_fh4 = 0;
        @(negedge CLK);
        RN = 1'b1;
        a_mode = M_PER;
        start_en();
        check_model(0, "rstmid_re");

        // Random A streams of varying density
        for (int run = 0; run < 6; run++) begin
            do_reset();
            a_prob = int'($urandom_range(75, 25));
            a_mode = M_RAND;
            start_en();
            for (int n = 0; n < 3; n++) check_model(n, $sformatf("rnd%0d_w%0d", run, n));
        end

        EN = 1'b0;
        repeat (3) @(negedge CLK);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/clk_sink_monitor.md
Name: clk_sink_monitor

Overview:
- Receive-end companion to the clock buffer cells.
- Samples a buffered clock or periodic net arriving at a sink (input A) in the local CLK domain.
- Counts its rising edges over fixed windows and flags lost, slow or runaway clocks.
- Sits at clock-tree leaves and divider outputs as a built-in health check; the verdict feeds status registers or reset logic.

Parameters:
- WIN_LEN, 64, window length in CLK cycles (>=4).
- CNT_W, 8, edge-counter width; saturates at 2^CNT_W-1.
- MIN_EDGES, 12, fewest rising edges per window still judged OK.
- MAX_EDGES, 20, most rising edges per window still judged OK (MIN_EDGES <= MAX_EDGES < 2^CNT_W).
- SYNC_STAGES, 2, synchronizer flops on A (>=2).

Ports:
- CLK  input  1  monitor clock, rising-edge.
- RN  input  1  asynchronous active-low reset.
- EN  input  1  monitor enable, synchronous level.
- A  input  1  monitored net, asynchronous to CLK.
- DONE  output  1  one-cycle pulse at each window verdict.
- OK  output  1  last window count within [MIN_EDGES, MAX_EDGES].
- FAIL_LOW  output  1  last window count < MIN_EDGES.
- FAIL_HIGH  output  1  last window count > MAX_EDGES.
- EDGE_CNT  output  CNT_W  edge count latched at the last verdict.

Behaviour:
- Reset: RN low asynchronously clears the synchronizer, edge-detect flop, all counters and all outputs. DONE=0, OK=0, FAIL_LOW=0, FAIL_HIGH=0, EDGE_CNT=0, state=IDLE.
- Synchronizer: A passes through SYNC_STAGES flops; the last stage feeds an edge-detect flop.
- Rising edge: last stage = 1 and edge-detect flop = 0. At most one edge is counted per CLK cycle.
- The synchronizer and edge-detect flop run in every state so history is never stale.
- Window length: A must toggle slower than CLK/2 for exact counts. Faster input aliases and is treated as FAIL_HIGH only if the aliased count exceeds MAX_EDGES.
- State IDLE: counters held at 0. EN=1 moves to SETTLE.
- State SETTLE: waits SYNC_STAGES+1 cycles (flush), with no counting, then moves to COUNT with window counter=0 and edge counter=0.
- State COUNT: window counter increments each cycle; the edge counter increments on each rising edge and saturates.
- COUNT exit: when the window counter = WIN_LEN-1, an edge in that cycle is still counted, and the next state is REPORT.
- State REPORT (1 cycle):
  - DONE=1.
  - EDGE_CNT <= edge counter.
  - Exactly one of OK/FAIL_LOW/FAIL_HIGH is set; the other two clear.
  - Edge counter reloads to 1 if an edge is present this cycle, else 0. The REPORT-cycle edge belongs to the next window.
  - Window counter reloads to 0.
  - Next state: COUNT if EN=1, else IDLE.
- Verdict latency: DONE rises exactly WIN_LEN+1 cycles after entering COUNT. Subsequent windows have a period of WIN_LEN+1 cycles.
- EN deasserted in SETTLE or COUNT: next state IDLE, the partial window is discarded, no DONE, and verdict outputs hold their last values.
- Verdict outputs and EDGE_CNT change only in REPORT or on reset.
- Reset mid-window: immediate clear to reset values. After RN rises, the block restarts from IDLE.

Optional Feature:
- Macro CLK_SINK_MONITOR_STICKY_EN.
- Defined: FAIL_LOW and FAIL_HIGH are sticky. Once set they stay 1 across later passing windows; OK is forced 0 while either is set. Only RN clears them. EDGE_CNT and DONE behave as normal.
- Undefined: flags reflect the most recent window only, as above.

Test Plan:
All scenarios use defaults (WIN_LEN=64, MIN_EDGES=12, MAX_EDGES=20).
- A period 4 CLK (4 edges per 16 cycles), EN=1 held -> first DONE 64+1 cycles after COUNT entry; EDGE_CNT=16, OK=1, both fail flags 0; repeats every 65 cycles.
- A held 0 -> DONE with EDGE_CNT=0, FAIL_LOW=1, OK=0. Then A period 4 -> next window OK=1, FAIL_LOW=0 without the macro; FAIL_LOW stays 1 and OK=0 with the macro.
- A period 2 CLK -> EDGE_CNT=32, FAIL_HIGH=1. With CNT_W=4, EDGE_CNT=15 (saturated) and FAIL_HIGH=1 (MAX_EDGES=12 for that run).
- Boundary counts: A edges placed to give exactly 12 and exactly 20 per window -> OK=1. Exactly 11 -> FAIL_LOW. Exactly 21 -> FAIL_HIGH. An edge in the last COUNT cycle is counted; an edge in the REPORT cycle appears in the next window.
- EN dropped at window cycle 30 -> no DONE, outputs unchanged, state IDLE. Re-raising EN gives SETTLE of 3 cycles, then a full window.
- RN pulsed low at window cycle 40 with OK=1 -> all outputs 0 on the same edge. After release with EN=1, first DONE arrives after the full SETTLE+COUNT+REPORT latency.
